// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: one outstanding load/store, lane alignment, load extension.
// Optional bus timeout watchdog is compiled in with `define DMEM_TIMEOUT_EN.
module data_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the response is a single-cycle resp_valid pulse with no back-pressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;

    logic        req_bad;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        timed_out;
    logic        bus_end;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    assign dbg_state = state;

    always_comb begin
        store_data = req_wdata;
        store_be   = 4'b1111;
        req_bad    = 1'b0;
        case (req_size)
            2'b00: begin
                store_data = {4{req_wdata[7:0]}};
                store_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                store_data = {2{req_wdata[15:0]}};
                store_be   = 4'b0011 << req_addr[1:0];
                req_bad    = req_addr[0];
            end
            2'b10:   req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Lane extraction uses the latched address/size, so bus_rdata is only consumed on ack.
    always_comb begin
        byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = bus_rdata;
        endcase
    end

    always_comb begin
        timed_out = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        timed_out = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        bus_end = bus_ack | bus_err | timed_out;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            lane_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        lane_q    <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= BUS;
                            bus_cyc   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_wdata <= req_we ? store_data : 32'h0;
                            bus_be    <= req_we ? store_be : 4'b1111;
`ifdef DMEM_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                        end
                    end
                end
                BUS: begin
                    if (bus_end) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        bus_cyc    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_wdata  <= '0;
                        bus_be     <= '0;
                        // Error beats ack; ack beats an expiring timeout.
                        if (bus_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (bus_ack) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= we_q ? 32'h0 : load_data;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end else begin
`ifdef DMEM_TIMEOUT_EN
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: spec-level model, scoreboard queue, literal pins.
// Timeout cases are exercised when DMEM_TIMEOUT_EN is defined.
module tb_data_mem_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_cyc;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q[$];        // {err, rdata}
    logic        exp_bus_we;
    logic [31:0] exp_bus_addr;
    logic [31:0] exp_bus_wdata;
    logic [3:0]  exp_bus_be;
    logic        cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        if (size == 2'b11) return 1'b1;
        nb = 1 << size;
        return (addr % nb) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [1:0] size,
                                            input logic [31:0] addr);
        int nb;
        int mask;
        if (!we) return 4'hF;
        nb   = 1 << size;
        mask = (1 << nb) - 1;
        return 4'(mask << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'b00) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] word);
        int nbits;
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 2'b10) return word;
        nbits = 8 << size;
        mask  = (32'h1 << nbits) - 1;
        v     = (word >> (8 * (addr % 4))) & mask;
        if (!uns && ((v >> (nbits - 1)) & 1) == 1) v = v | ~mask;
        return v;
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clock) begin
        if (cmp_en) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
                end
            end else begin
                check("resp_idle_zero", {31'd0, resp_err} | resp_rdata, 32'd0);
            end
            if (bus_cyc) begin
                check("bus_addr", bus_addr, exp_bus_addr);
                check("bus_be", {28'd0, bus_be}, {28'd0, exp_bus_be});
                check("bus_we", {31'd0, bus_we}, {31'd0, exp_bus_we});
                check("ready_busy", {31'd0, req_ready}, 32'd0);
                if (exp_bus_we) check("bus_wdata", bus_wdata, exp_bus_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_be;

    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits,
                           input logic give_ack, input logic give_err, input int reset_at);
        int   g;
        int   bus_n;
        int   exp_bus_n;
        logic bad;
        logic to_exp;
        logic exp_err;
        logic [31:0] exp_rd;

        @(negedge clock);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        check("ready_wait", {31'd0, req_ready}, 32'd1);

        bad    = model_bad(size, addr);
        to_exp = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        if (!bad && (!(give_ack || give_err) || waits + 1 > TO)) to_exp = 1'b1;
`endif
        exp_bus_n = bad ? 0 : (to_exp ? TO : waits + 1);
        exp_err   = bad | give_err | to_exp;
        exp_rd    = (exp_err || we) ? 32'h0 : model_load(size, uns, addr, rdata);
        if (reset_at == 0) exp_q.push_back({exp_err, exp_rd});
        exp_bus_we    = we;
        exp_bus_addr  = addr & 32'hFFFF_FFFC;
        exp_bus_wdata = model_wdata(size, wdata);
        exp_bus_be    = model_be(we, size, addr);

        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;

        lat = 0; bus_n = 0; got_rdata = '0; got_err = 1'b0;
        snap_addr = '0; snap_wdata = '0; snap_be = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (reset_at != 0 && k == reset_at + 1) begin
                reset = 1'b0;
                check("rst_bus_cyc", {31'd0, bus_cyc}, 32'd0);
                check("rst_req_ready", {31'd0, req_ready}, 32'd1);
                check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
                bus_ack = 1'b0;
                bus_err = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check("rst_no_resp_after", {31'd0, resp_valid}, 32'd0);
                end
                return;
            end
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_err = resp_err;
                bus_ack = 1'b0; bus_err = 1'b0;
                break;
            end
            if (bus_cyc) begin
                bus_n++;
                if (bus_n == 1) begin
                    snap_addr = bus_addr; snap_wdata = bus_wdata; snap_be = bus_be;
                end
            end
            bus_ack   = bus_cyc && (k == waits + 1) && give_ack;
            bus_err   = bus_cyc && (k == waits + 1) && give_err;
            bus_rdata = rdata;
            if (reset_at != 0 && k == reset_at) reset = 1'b1;
        end
        if (lat == 0) begin
            check("resp_never_came", 32'd0, 32'd1);
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
        check("bus_cycles", bus_n, exp_bus_n);
        check("latency", lat, bad ? 1 : exp_bus_n + 1);
        @(negedge clock);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clock);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_cyc", {31'd0, bus_cyc}, 32'd0);
        check("reset_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("reset_bus_be", {28'd0, bus_be}, 32'd0);
        check("reset_rdata", resp_rdata | bus_addr | bus_wdata, 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // store byte at 0x1003
        run_txn(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 0, 1'b1, 1'b0, 0);
        check("sb_addr", snap_addr, 32'h1000);
        check("sb_wdata", snap_wdata, 32'hABAB_ABAB);
        check("sb_be", {28'd0, snap_be}, 32'h8);
        check("sb_lat", lat, 2);
        check("sb_err", {31'd0, got_err}, 32'd0);

        // load half signed / unsigned at 0x2002
        run_txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h80FF_1234, 0, 1'b1, 1'b0, 0);
        check("lh_signed", got_rdata, 32'hFFFF_80FF);
        run_txn(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h80FF_1234, 0, 1'b1, 1'b0, 0);
        check("lh_unsigned", got_rdata, 32'h0000_80FF);

        // misaligned word load
        run_txn(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h1111_1111, 0, 1'b1, 1'b0, 0);
        check("mis_lat", lat, 1);
        check("mis_err", {31'd0, got_err}, 32'd1);

        // three wait states
        run_txn(1'b0, 2'b10, 1'b0, 32'h0044, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, 0);
        check("ws_lat", lat, 5);
        check("ws_rdata", got_rdata, 32'hDEAD_BEEF);

        // ack and err together
        run_txn(1'b0, 2'b10, 1'b0, 32'h0048, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b1, 0);
        check("ackerr_err", {31'd0, got_err}, 32'd1);
        check("ackerr_rdata", got_rdata, 32'd0);

        // slave error on a store, illegal size, misaligned half
        run_txn(1'b1, 2'b10, 1'b0, 32'h0050, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 1'b1, 0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h0060, 32'h0, 32'h0, 0, 1'b1, 1'b0, 0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, 32'h0, 0, 1'b1, 1'b0, 0);

        // byte loads across all lanes, signed and unsigned
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, 2'b00, 1'(i / 4), 32'h0100 + 32'(i % 4), 32'h0, 32'h7F80_C301,
                    i % 3, 1'b1, 1'b0, 0);
            if (i == 1) check("lb_lane1_signed", got_rdata, 32'hFFFF_FFC3);
            if (i == 6) check("lb_lane2_unsigned", got_rdata, 32'h0000_0080);
        end

        // half and word stores
        run_txn(1'b1, 2'b01, 1'b0, 32'h0006, 32'h1234_ABCD, 32'h0, 1, 1'b1, 1'b0, 0);
        check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        check("sh_be", {28'd0, snap_be}, 32'hC);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0008, 32'h0BAD_CAFE, 32'h0, 0, 1'b1, 1'b0, 0);
        check("sw_wdata", snap_wdata, 32'h0BAD_CAFE);

        // bus responses while idle are ignored
        @(negedge clock);
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check("idle_ack_ignored", {30'd0, resp_valid, bus_cyc}, 32'd0);
            check("idle_ready", {31'd0, req_ready}, 32'd1);
        end
        bus_ack = 1'b0; bus_err = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        run_txn(1'b0, 2'b10, 1'b0, 32'h0070, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0, 0);
        check("to_lat", lat, 5);
        check("to_err", {31'd0, got_err}, 32'd1);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0074, 32'h0, 32'h5555_AAAA, 3, 1'b1, 1'b0, 0);
        check("to_edge_err", {31'd0, got_err}, 32'd0);
        check("to_edge_rdata", got_rdata, 32'h5555_AAAA);
`endif

        // reset during the third wait cycle, then a normal word load
        run_txn(1'b0, 2'b10, 1'b0, 32'h0080, 32'h0, 32'h0, 10, 1'b1, 1'b0, 3);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, 32'h1357_2468, 0, 1'b1, 1'b0, 0);
        check("post_rst_rdata", got_rdata, 32'h1357_2468);
        check("post_rst_lat", lat, 2);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory access controller between the core's memory stage and the data memory bus. Accepts one load/store request at a time and aligns store data and byte enables onto 32-bit word lanes. Drives a single-outstanding ack-based bus transaction and returns sign- or zero-extended load data with an error flag. Removes all lane and wait-state handling from the core FSM, which stalls in its memory states until `resp_valid` is asserted.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum bus cycles waited for `bus_ack`/`bus_err`; only used when the timeout feature is compiled in.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  controller idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- `req_unsigned`  in  1  load zero-extends when 1.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access, illegal size, bus error or timeout.
- `bus_cyc`  out  1  transaction active.
- `bus_we`  out  1  write strobe.
- `bus_addr`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables; all 1111 for loads.
- `bus_ack`  in  1  transaction complete, `bus_rdata` valid.
- `bus_err`  in  1  slave error, terminates the transaction.
- `bus_rdata`  in  32  read word.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`, latch `req_*` into internal registers.
  - Misaligned request: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `req_size`=11. Go to RESP with error; no bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - `bus_cyc`=1. `bus_we`, `bus_addr`, `bus_wdata` and `bus_be` come from registers and stay stable for the whole state.
  - On `bus_ack`, capture the formatted read data, then go to RESP.
  - On `bus_err`, go to RESP with error.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE. `req_ready`=0.
- Store lanes:
  - Byte: `bus_wdata`=`{4{wdata[7:0]}}`, `bus_be`=`4'b0001<<addr[1:0]`.
  - Half: `{2{wdata[15:0]}}`, `4'b0011<<addr[1:0]`.
  - Word: passthrough, 1111.
- Load extraction:
  - Byte: lane `bus_rdata[8*addr[1:0]+:8]`.
  - Half: `bus_rdata[16*addr[1]+:16]`.
  - Both are extended from their MSB, or zero-extended when `req_unsigned`=1.
  - Word: passthrough; `req_unsigned` is ignored.
- Simultaneous `bus_ack` and `bus_err`: error wins, and `resp_rdata`=0.
- `bus_ack`/`bus_err` arriving while not in BUS are ignored.
- `req_*` inputs change without effect outside the IDLE accept cycle.

## Timing
- Reset values: state IDLE, `req_ready`=1, all other outputs 0, timeout counter 0.
- Reset asserted mid-transaction: takes effect at the next edge. `bus_cyc` drops at that edge and no response is produced.
- Zero-wait slave (ack in first BUS cycle):
  - Request accepted at edge 0.
  - `bus_cyc` high during cycle 0–1.
  - `resp_valid` during cycle 1–2.
  - 2 cycles request-to-response; each added wait state adds 1.
- Misaligned or illegal request: `resp_valid` one cycle after acceptance, with `resp_err`=1.
- Back-to-back throughput: one transaction per 3 cycles. `req_ready` returns to 1 in the cycle after RESP.
- `resp_rdata` and `resp_err` are registered and valid only while `resp_valid`=1. They are 0 otherwise.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entering BUS and increments each BUS cycle without `bus_ack`/`bus_err`.
  - When it reaches `TIMEOUT_CYCLES`, `bus_cyc` drops and RESP is entered with `resp_err`=1.
  - `bus_ack` in the expiry cycle wins: normal completion, no error.
- `DMEM_TIMEOUT_EN` undefined: no counter is built, and BUS waits indefinitely.

## Test plan
- Store byte:
  - Stimulus: `addr`=0x1003, `wdata`=0x000000AB, `size`=00, zero-wait.
  - Required: `bus_addr`=0x1000, `bus_wdata`=0xABABABAB, `bus_be`=1000, `resp_valid` 2 cycles after accept, `resp_err`=0.
- Load half signed vs unsigned:
  - Stimulus: `addr`=0x2002, `bus_rdata`=0x80FF1234.
  - Required: `resp_rdata`=0xFFFF80FF; with `req_unsigned`=1, 0x000080FF.
- Misaligned word load at 0x3001:
  - Required: `bus_cyc` never asserted, `resp_valid`+`resp_err` 1 cycle after accept.
- Wait states and error:
  - Stimulus: ack after 3 wait cycles.
  - Required: response 5 cycles after accept, with `bus_*` stable throughout.
  - Then: `bus_ack`=`bus_err`=1 together gives `resp_err`=1, `resp_rdata`=0.
- Timeout with `DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4:
  - No ack: `bus_cyc` drops after 4 BUS cycles, `resp_err`=1.
  - Ack on 4th cycle: normal completion.
- Reset asserted during BUS on a 3rd wait cycle:
  - Required: next edge gives `bus_cyc`=0, `req_ready`=1, no `resp_valid`.
  - Then: a following word load at 0x0 completes normally.
